shift_add_multiplier: RTL and testbench



---
 rtl/shift_add_multiplier.sv | 107 ++++++++++
 tb/tb_shift_add_multiplier.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_add_multiplier.sv
// ============================================================================
// shift_add_multiplier
//   Sequential unsigned shift-and-add multiplier. It retires one multiplier
//   bit per clock and returns a 2*WIDTH-bit product with a one-cycle DONE
//   pulse.
//
//   Optional feature: define MULT_EARLY_EXIT_EN to end the run on the edge
//   where the shifted multiplier becomes zero. The product is unchanged; only
//   the latency becomes data-dependent.
//
// Ports
//   CLK    in   1        rising-edge clock
//   RSTN   in   1        asynchronous active-low reset
//   START  in   1        request, accepted only while BUSY=0
//   A      in   WIDTH    multiplicand (unsigned), captured on accept
//   B      in   WIDTH    multiplier (unsigned), captured on accept
//   DO     out  2*WIDTH  product register, holds until next completion
//   BUSY   out  1        multiplication in progress
//   DONE   out  1        one-cycle pulse, DO is new in this cycle
// ============================================================================
module shift_add_multiplier #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    input  logic                 START,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   DO,
    output logic                 BUSY,
    output logic                 DONE
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    logic [PW-1:0]      r_mcand;
    logic [PW-1:0]      r_acc;
    logic [WIDTH-1:0]   r_mplier;
    logic [CW-1:0]      r_cnt;

    logic [PW-1:0]      w_acc_next;
    logic [WIDTH-1:0]   w_mplier_next;
    logic               w_last;

    // Partial-product add for the current multiplier LSB
    assign w_acc_next    = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_mplier_next = r_mplier >> 1;

`ifdef MULT_EARLY_EXIT_EN
    // Stop once no set bits remain; the counter still bounds the run
    assign w_last = (r_cnt == CW'(1)) || (w_mplier_next == '0);
`else
    assign w_last = (r_cnt == CW'(1));
`endif

    // Control FSM and datapath registers
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state  <= S_IDLE;
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            DO       <= '0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (START) begin
                        r_mcand  <= PW'(A);
                        r_mplier <= B;
                        r_acc    <= '0;
                        r_cnt    <= CW'(WIDTH);
                        BUSY     <= 1'b1;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= w_mplier_next;
                    r_cnt    <= r_cnt - CW'(1);
                    if (w_last) begin
                        DO      <= w_acc_next;
                        DONE    <= 1'b1;
                        BUSY    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    BUSY    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// ============================================================================
// tb_shift_add_multiplier
//   Self-checking bench. A cycle-level behavioural model predicts DO, BUSY
//   and DONE from accept time, product and latency; every cycle is compared.
//   Directed cases pin literal products and latencies; random cases follow.
// ============================================================================
module tb_shift_add_multiplier;

    localparam int unsigned W = 8;

    logic           CLK;
    logic           RSTN;
    logic           START;
    logic [W-1:0]   A;
    logic [W-1:0]   B;
    logic [2*W-1:0] DO;
    logic           BUSY;
    logic           DONE;

    int n_checks = 0;
    int n_pass   = 0;
    bit started  = 0;

    shift_add_multiplier #(.WIDTH(W)) dut (
        .CLK  (CLK),
        .RSTN (RSTN),
        .START(START),
        .A    (A),
        .B    (B),
        .DO   (DO),
        .BUSY (BUSY),
        .DONE (DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Number of iterations for a given multiplier value
    function automatic int iter_count(input logic [W-1:0] b);
`ifdef MULT_EARLY_EXIT_EN
        int hi = 0;
        if (b == '0) return 1;
        for (int i = 0; i < int'(W); i++) if (b[i]) hi = i;
        return hi + 1;
`else
        return int'(W);
`endif
    endfunction

    function automatic int sel_lat(input int full_lat, input int early_lat);
`ifdef MULT_EARLY_EXIT_EN
        return early_lat;
`else
        return full_lat;
`endif
    endfunction

    // ---------------- behavioural model ----------------
    longint         cyc = 0;
    bit             m_pending = 0;
    longint         m_done_cyc = 0;
    logic [2*W-1:0] m_prod = '0;
    logic [2*W-1:0] exp_do = '0;
    logic           exp_done = 1'b0;
    logic           exp_busy = 1'b0;

    always @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            m_pending = 0;
            exp_do    = '0;
            exp_done  = 1'b0;
            exp_busy  = 1'b0;
        end else begin
            cyc++;
            exp_done = 1'b0;
            if (m_pending && cyc == m_done_cyc) begin
                exp_do    = m_prod;
                exp_done  = 1'b1;
                m_pending = 0;
            end else if (!m_pending && START) begin
                m_prod     = (2*W)'(A) * (2*W)'(B);
                m_done_cyc = cyc + longint'(iter_count(B));
                m_pending  = 1;
            end
            exp_busy = m_pending;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge CLK) begin
        if (started) begin
            chk("cyc_DO",   64'(DO),   64'(exp_do));
            chk("cyc_BUSY", 64'(BUSY), 64'(exp_busy));
            chk("cyc_DONE", 64'(DONE), 64'(exp_done));
        end
    end

    time last_done_t = 0;

    // Called at a negedge; returns at the negedge where DONE is seen.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] exp_p, input int lat,
                          input bit inject);
        int  i;
        int  busy_cnt;
        bit  seen;
        #1;
        START = 1'b1; A = a; B = b;
        @(posedge CLK);
        #1;
        START = 1'b0; A = W'($urandom); B = W'($urandom);
        busy_cnt = 0;
        seen = 0;
        for (i = 1; i <= 100; i++) begin
            @(negedge CLK);
            if (DONE) begin
                seen = 1;
                break;
            end
            if (BUSY) busy_cnt++;
            if (inject && i == 3) begin
                #1; START = 1'b1; A = 8'd5; B = 8'd5;
            end else if (inject && i == 4) begin
                #1; START = 1'b0;
            end
        end
        chk("done_seen", 64'(seen), 64'(1));
        chk("latency",   64'(i - 1), 64'(lat));
        chk("busy_cycles", 64'(busy_cnt), 64'(lat));
        chk("product",   64'(DO), 64'(exp_p));
        last_done_t = $time;
    endtask

    initial begin
        time t1;
        logic [W-1:0] ra, rb;
        int lat;
        START = 1'b0; A = '0; B = '0;
        RSTN  = 1'b1;
        #2 RSTN = 1'b0;
        started = 1;
        repeat (3) @(negedge CLK);
        chk("rst_DO",   64'(DO),   64'(16'h0000));
        chk("rst_BUSY", 64'(BUSY), 64'(0));
        chk("rst_DONE", 64'(DONE), 64'(0));
        #1 RSTN = 1'b1;

        // Basic
        @(negedge CLK);
        run_op(8'd13, 8'd11, 16'h008F, sel_lat(8, 4), 0);

        // Max operands
        @(negedge CLK);
        run_op(8'd255, 8'd255, 16'hFE01, 8, 0);
        @(negedge CLK);
        chk("single_pulse", 64'(DONE), 64'(0));

        // Zero product, START re-pulsed while running
        run_op(8'd0, 8'd200, 16'h0000, 8, 1);
        repeat (4) @(negedge CLK);
        chk("do_held", 64'(DO), 64'(16'h0000));

        // Back-to-back: second START in the DONE cycle
        run_op(8'd3, 8'd7, 16'h0015, sel_lat(8, 3), 0);
        t1 = last_done_t;
        run_op(8'd100, 8'd2, 16'h00C8, sel_lat(8, 2), 0);
        chk("b2b_gap", 64'((last_done_t - t1) / 10), 64'(sel_lat(9, 3)));

        // Reset mid-operation
        @(negedge CLK);
        #1 START = 1'b1; A = 8'd9; B = 8'd9;
        @(posedge CLK);
        #1 START = 1'b0;
        repeat (3) @(negedge CLK);
        #1 RSTN = 1'b0;
        @(negedge CLK);
        chk("abort_DO",   64'(DO),   64'(16'h0000));
        chk("abort_BUSY", 64'(BUSY), 64'(0));
        chk("abort_DONE", 64'(DONE), 64'(0));
        repeat (2) @(negedge CLK);
        #1 RSTN = 1'b1;
        repeat (12) @(negedge CLK);
        chk("no_done_after_abort", 64'(DO), 64'(16'h0000));
        run_op(8'd9, 8'd9, 16'h0051, sel_lat(8, 4), 0);

        // Early-exit boundary operands
        @(negedge CLK);
        run_op(8'd123, 8'd0, 16'h0000, sel_lat(8, 1), 0);
        @(negedge CLK);
        run_op(8'd77, 8'd1, 16'h004D, sel_lat(8, 1), 0);
        @(negedge CLK);
        run_op(8'd3, 8'h10, 16'h0030, sel_lat(8, 5), 0);

        // Random operations, random gaps, random ignored STARTs
        for (int k = 0; k < 150; k++) begin
            repeat ($urandom_range(0, 2)) @(negedge CLK);
            ra = W'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? W'(1 << $urandom_range(0, W-1)) : W'($urandom);
            if ($urandom_range(0, 9) == 0) rb = '0;
            lat = iter_count(rb);
            if ($urandom_range(0, 4) == 0) begin
                run_op(ra, rb, (2*W)'(ra) * (2*W)'(rb), lat, 0);
            end else begin
                @(negedge CLK);
                run_op(ra, rb, (2*W)'(ra) * (2*W)'(rb), lat, (lat >= 5) && $urandom_range(0, 1) == 1);
            end
        end

        repeat (3) @(negedge CLK);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
